config_loader: RTL and testbench

Bitstream writer for the fabric's serial configuration chain. It drives the config_in, config_clk and config_en pins of top.
- Accepts the bitstream as parallel words over a valid/ready handshake.
- Serialises exactly CONFIG_WIDTH bits into the chain, generating config_clk from clk.
- Captures config_out as it shifts, packs it into words, and returns it as a readback stream, giving both ends of the chain in one block.
- Sits between a host or bench word source and the top instance.

---
 rtl/cfg_pkg.sv | 26 ++
 rtl/cfg_clk_gen.sv | 23 ++
 rtl/config_loader.sv | 90 +++++++++
 tb/tb_config_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared state encoding and configuration-chain sizing for the 5x3 mesh
package cfg_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, DONE} state_t;
  localparam int MESH_SIZE_X = 5;
  localparam int MESH_SIZE_Y = 3;
  localparam int IO_BITS_PER_PIN = 6;
  localparam int CLB_BITS = 267;
  localparam int CX_BITS = 64;
  localparam int SWBX_BITS = 40;
  function automatic int io_config_width(input int x, input int y);
    return 2 * (x + y) * IO_BITS_PER_PIN;
  endfunction
  function automatic int clb_config_width(input int x, input int y);
    return x * y * CLB_BITS;
  endfunction
  function automatic int cx_config_width(input int x, input int y);
    return ((x + 1) * y + x * (y + 1)) * CX_BITS;
  endfunction
  function automatic int swbx_config_width(input int x, input int y);
    return (x + 1) * (y + 1) * SWBX_BITS;
  endfunction
  function automatic int config_width(input int x, input int y);
    return io_config_width(x, y) + clb_config_width(x, y) + cx_config_width(x, y) + swbx_config_width(x, y);
  endfunction
  localparam int CONFIG_WIDTH_DEFAULT = config_width(MESH_SIZE_X, MESH_SIZE_Y);
endpackage

// File: rtl/cfg_clk_gen.sv
// cfg_clk_gen: half-period divider; tick ends each phase, config_clk toggles on tick while run, held low otherwise
module cfg_clk_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic config_clk
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = run && cnt == CW'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      config_clk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      config_clk <= tick ? ~config_clk : config_clk;
    end
  end
endmodule

// File: rtl/config_loader.sv
// config_loader: word-fed serial config chain writer with word-packed readback of the chain tail
module config_loader
  import cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = CONFIG_WIDTH_DEFAULT,
  parameter int WORD_WIDTH = 32,
  parameter int CFG_CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  sys_reset,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  rb_valid,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  config_in,
  output logic                  config_clk,
  output logic                  config_en,
  input  logic                  config_out
);
  localparam int BIT_CNT_W = $clog2(CONFIG_WIDTH + 1);
  localparam int WB_W = $clog2(WORD_WIDTH);
  state_t state;
  logic [WORD_WIDTH-1:0] shreg, rb_shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [WB_W-1:0] word_bit;
  logic run, tick, last_bit, last_word;
  assign run = state == LOW || state == HIGH;
  assign last_bit = bit_cnt == BIT_CNT_W'(CONFIG_WIDTH - 1);
  assign last_word = word_bit == WB_W'(WORD_WIDTH - 1);
  assign s_ready = state == FETCH;
  assign busy = state == FETCH || run;
  assign config_en = busy;
  assign done = state == DONE;
  assign config_in = shreg[0];
  cfg_clk_gen #(.DIV(CFG_CLK_DIV)) u_clk_gen (
    .clk(clk),
    .rst(sys_reset),
    .run(run),
    .tick(tick),
    .config_clk(config_clk)
  );
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state <= IDLE;
      shreg <= '0;
      rb_shreg <= '0;
      rb_data <= '0;
      rb_valid <= 1'b0;
      bit_cnt <= '0;
      word_bit <= '0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          bit_cnt <= '0;
        end
        FETCH: if (s_valid) begin
          shreg <= s_data;
          word_bit <= '0;
          state <= LOW;
        end
        LOW: if (tick) begin
          rb_shreg[word_bit] <= config_out;
          state <= HIGH;
        end
        HIGH: if (tick) begin
          shreg <= shreg >> 1;
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          word_bit <= word_bit + WB_W'(1);
          if (last_bit || last_word) begin
            rb_valid <= 1'b1;
            rb_data <= rb_shreg;
            rb_shreg <= '0;
          end
          state <= last_bit ? DONE : last_word ? FETCH : LOW;
        end
        DONE: begin
          shreg <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: table-driven check of config_loader against shift-register chain models
module tb_config_loader;
  logic clk = 1'b0;
  logic sys_reset, start, s_valid, sel, stalling, clr, pre_stb;
  logic [7:0] s_data;
  logic [39:0] pv;
  logic s_ready, rb_valid, busy, done, config_in, config_clk, config_en, config_out;
  logic [7:0] rb_data;
  logic s_ready_p, rb_valid_p, busy_p, done_p, config_in_p, config_clk_p, config_en_p, config_out_p;
  logic [7:0] rb_data_p;
  logic [39:0] chain;
  logic [36:0] chain_p;
  int edges, edges_p, cyc;
  int checks = 0, failures = 0;
  int rb_n, done_n, en_bad, stall_bad, stall_obs;
  logic [39:0] rb_acc;
  logic m_ready, m_rb_valid, m_done, m_busy, m_en, m_cclk;
  logic [7:0] m_rb_data;

  always #5 clk = ~clk;

  config_loader #(.CONFIG_WIDTH(40), .WORD_WIDTH(8), .CFG_CLK_DIV(1)) dut (
    .clk(clk), .sys_reset(sys_reset), .start(start && !sel), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .rb_valid(rb_valid), .rb_data(rb_data), .busy(busy), .done(done),
    .config_in(config_in), .config_clk(config_clk), .config_en(config_en), .config_out(config_out)
  );
  config_loader #(.CONFIG_WIDTH(37), .WORD_WIDTH(8), .CFG_CLK_DIV(1)) dut_p (
    .clk(clk), .sys_reset(sys_reset), .start(start && sel), .s_valid(s_valid), .s_ready(s_ready_p),
    .s_data(s_data), .rb_valid(rb_valid_p), .rb_data(rb_data_p), .busy(busy_p), .done(done_p),
    .config_in(config_in_p), .config_clk(config_clk_p), .config_en(config_en_p), .config_out(config_out_p)
  );

  assign config_out = chain[0];
  assign config_out_p = chain_p[0];
  assign m_ready = sel ? s_ready_p : s_ready;
  assign m_rb_valid = sel ? rb_valid_p : rb_valid;
  assign m_rb_data = sel ? rb_data_p : rb_data;
  assign m_done = sel ? done_p : done;
  assign m_busy = sel ? busy_p : busy;
  assign m_en = sel ? config_en_p : config_en;
  assign m_cclk = sel ? config_clk_p : config_clk;

  always @(posedge config_clk or posedge pre_stb)
    if (pre_stb) begin
      chain <= pv;
      edges <= 0;
    end else begin
      edges <= edges + 1;
      if (config_en) chain <= {config_in, chain[39:1]};
    end

  always @(posedge config_clk_p or posedge pre_stb)
    if (pre_stb) begin
      chain_p <= pv[36:0];
      edges_p <= 0;
    end else begin
      edges_p <= edges_p + 1;
      if (config_en_p) chain_p <= {config_in_p, chain_p[36:1]};
    end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (clr) begin
      rb_n <= 0; rb_acc <= '0; done_n <= 0; en_bad <= 0; stall_bad <= 0; stall_obs <= 0;
    end else begin
      if (m_rb_valid) begin
        if (rb_n < 5) rb_acc[rb_n*8 +: 8] <= m_rb_data;
        rb_n <= rb_n + 1;
      end
      if (m_done) done_n <= done_n + 1;
      if (m_busy && !m_en) en_bad <= en_bad + 1;
      if (stalling) begin
        stall_obs <= stall_obs + 1;
        if (m_cclk || !m_en || !m_ready) stall_bad <= stall_bad + 1;
      end
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic prep(input logic [39:0] pre);
    pv = pre;
    pre_stb = 1'b1;
    #1 pre_stb = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    clr = 1'b0;
  endtask

  task automatic load(input logic [39:0] w, input int stall_at, output int lat);
    int t0, n;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == stall_at) begin
        s_valid = 1'b0;
        n = 0;
        while (!m_ready && n < 200) begin @(negedge clk); n++; end
        stalling = 1'b1;
        repeat (10) @(negedge clk);
        stalling = 1'b0;
      end
      s_data = w[i*8 +: 8];
      s_valid = 1'b1;
      n = 0;
      while (!m_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("handshake_timeout", 64'(n), 0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    n = 0;
    while (!m_done && n < 300) begin @(negedge clk); n++; end
    if (m_done) lat = cyc - t0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_edges(input int target);
    int n = 0;
    while (edges < target && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("edge_wait_timeout", 64'(edges), 64'(target));
  endtask

  typedef struct {
    bit part;
    logic [39:0] pre, words, exp_chain, exp_rb;
    int stall_at, exp_edges, exp_lat;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int lat;
    sys_reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; sel = 1'b0;
    stalling = 1'b0; clr = 1'b0; pre_stb = 1'b0; pv = '0;
    vecs[0] = '{1'b0, 40'h0, 40'h81_00_FF_3C_A5, 40'h81_00_FF_3C_A5, 40'h0, -1, 40, 86};
    vecs[1] = '{1'b0, 40'h01_23_45_67_89, 40'h0, 40'h0, 40'h01_23_45_67_89, -1, 40, 86};
    vecs[2] = '{1'b0, 40'h01_23_45_67_89, 40'h81_00_FF_3C_A5, 40'h81_00_FF_3C_A5, 40'h01_23_45_67_89, 2, 40, 96};
    vecs[3] = '{1'b1, 40'h15_55_55_55_55, 40'hFF_FF_FF_FF_FF, 40'h1F_FF_FF_FF_FF, 40'h15_55_55_55_55, -1, 37, 80};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {s_ready, rb_valid, rb_data, busy, done, config_in, config_clk, config_en}, 0);
    chk("reset_outputs_p", {s_ready_p, rb_valid_p, rb_data_p, busy_p, done_p, config_in_p, config_clk_p, config_en_p}, 0);
    sys_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = vecs[k].part;
      prep(vecs[k].pre);
      load(vecs[k].words, vecs[k].stall_at, lat);
      chk($sformatf("v%0d_edges", k), 64'(sel ? edges_p : edges), 64'(vecs[k].exp_edges));
      chk($sformatf("v%0d_chain", k), sel ? {3'b0, chain_p} : chain, vecs[k].exp_chain);
      chk($sformatf("v%0d_readback", k), rb_acc, vecs[k].exp_rb);
      chk($sformatf("v%0d_rb_pulses", k), 64'(rb_n), 5);
      chk($sformatf("v%0d_done_pulses", k), 64'(done_n), 1);
      chk($sformatf("v%0d_done_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
      chk($sformatf("v%0d_en_gaps", k), 64'(en_bad), 0);
      chk($sformatf("v%0d_busy_after", k), 64'(m_busy), 0);
      if (vecs[k].stall_at >= 0) begin
        chk($sformatf("v%0d_stall_bad", k), 64'(stall_bad), 0);
        chk($sformatf("v%0d_stall_seen", k), 64'(stall_obs >= 9), 1);
      end
    end
    sel = 1'b0;
    prep(40'h01_23_45_67_89);
    fork
      load(40'h81_00_FF_3C_A5, -1, lat);
      wait_edges(17);
    join_any
    disable fork;
    chk("pre_reset_busy", 64'(busy), 1);
    sys_reset = 1'b1; start = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("midop_reset_outputs", {s_ready, rb_valid, rb_data, busy, done, config_in, config_clk, config_en}, 0);
    sys_reset = 1'b0;
    prep(40'h0);
    load(40'h5A_C3_0F_96_E1, -1, lat);
    chk("reload_chain", chain, 40'h5A_C3_0F_96_E1);
    chk("reload_edges", 64'(edges), 40);
    prep(40'h0);
    fork
      load(40'h81_00_FF_3C_A5, -1, lat);
      begin
        wait_edges(20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    chk("busy_start_edges", 64'(edges), 40);
    chk("busy_start_done", 64'(done_n), 1);
    chk("busy_start_chain", chain, 40'h81_00_FF_3C_A5);
    chk("busy_start_latency", 64'(lat), 86);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
